// File: rtl/antares_div_pkg.sv
// Shared types and constants for the antares sequential divider.
package antares_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  localparam int unsigned DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = '1;

endpackage

// File: rtl/antares_div_abs.sv
// Combinational magnitude and sign extraction of one division operand.
module antares_div_abs
  import antares_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  input  logic             is_signed,
  output logic [WIDTH-1:0] mag,
  output logic             neg
);

  assign neg = is_signed & value[WIDTH-1];
  assign mag = neg ? (~value + 1'b1) : value;

endmodule

// File: rtl/antares_seq_divider.sv
// Radix-2 restoring divider feeding HILO for DIV/DIVU, with flush abort.
// Optional ANTARES_DIV_EARLY_EXIT_EN skips iteration when |dividend| < |divisor|.
module antares_seq_divider
  import antares_div_pkg::*;
#(
  parameter  int unsigned WIDTH = DIV_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_divs,
  input  logic             op_divu,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             div_abort,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_stall,
  output logic             div_done
);

  localparam logic [WIDTH-1:0] ZERO_Q = {WIDTH{DIV_BY_ZERO_Q[0]}};

  div_state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q_reg, rem_reg, dvs_reg, dvd_raw;
  logic             neg_q, neg_r, div_zero;

  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             dvd_neg, dvs_neg;
  logic             start, early_exit;

  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] q_fix, r_fix;

  antares_div_abs #(.WIDTH(WIDTH)) u_abs_dividend (
    .value     (dividend),
    .is_signed (op_divs),
    .mag       (dvd_mag),
    .neg       (dvd_neg)
  );

  antares_div_abs #(.WIDTH(WIDTH)) u_abs_divisor (
    .value     (divisor),
    .is_signed (op_divs),
    .mag       (dvs_mag),
    .neg       (dvs_neg)
  );

  assign start = (op_divs | op_divu) & ~div_abort;

`ifdef ANTARES_DIV_EARLY_EXIT_EN
  assign early_exit = (divisor != '0) && (dvd_mag < dvs_mag);
`else
  assign early_exit = 1'b0;
`endif

  // Remainder stays below the divisor magnitude, so WIDTH+1 bits hold the shifted partial.
  always_comb begin
    partial = {rem_reg, q_reg[WIDTH-1]};
    ge      = partial >= {1'b0, dvs_reg};
    diff    = partial[WIDTH-1:0] - dvs_reg;
    q_fix   = neg_q ? (~q_reg + 1'b1) : q_reg;
    r_fix   = neg_r ? (~rem_reg + 1'b1) : rem_reg;
    if (div_zero) begin
      q_fix = ZERO_Q;
      r_fix = dvd_raw;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = early_exit ? FIX : RUN;
      RUN: begin
        if (div_abort)                       state_nxt = IDLE;
        else if (cnt == CNT_W'(WIDTH - 1))   state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      q_reg     <= '0;
      rem_reg   <= '0;
      dvs_reg   <= '0;
      dvd_raw   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_stall <= 1'b0;
      div_done  <= 1'b0;
    end else begin
      div_stall <= (state_nxt != IDLE);
      div_done  <= (state == FIX) && !div_abort;
      unique case (state)
        IDLE: begin
          if (start) begin
            q_reg    <= early_exit ? '0 : dvd_mag;
            rem_reg  <= early_exit ? dvd_mag : '0;
            dvs_reg  <= dvs_mag;
            dvd_raw  <= dividend;
            neg_q    <= dvd_neg ^ dvs_neg;
            neg_r    <= dvd_neg;
            div_zero <= (divisor == '0);
            cnt      <= '0;
          end
        end
        RUN: begin
          if (!div_abort) begin
            rem_reg <= ge ? diff : partial[WIDTH-1:0];
            q_reg   <= {q_reg[WIDTH-2:0], ge};
            cnt     <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (!div_abort) begin
            quotient  <= q_fix;
            remainder <= r_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_antares_seq_divider.sv
// Directed self-checking bench for antares_seq_divider (WIDTH = 32).
module tb_antares_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_divs, op_divu, div_abort;
  logic [31:0] dividend, divisor;
  logic [31:0] quotient, remainder;
  logic        div_stall, div_done;

  int n_checks = 0;
  int n_fail   = 0;

  antares_seq_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_divs   (op_divs),
    .op_divu   (op_divu),
    .dividend  (dividend),
    .divisor   (divisor),
    .div_abort (div_abort),
    .quotient  (quotient),
    .remainder (remainder),
    .div_stall (div_stall),
    .div_done  (div_done)
  );

  always #5 clk = ~clk;

`ifdef ANTARES_DIV_EARLY_EXIT_EN
  localparam int SMALL_STALL = 1;
`else
  localparam int SMALL_STALL = 33;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start at cycle 0, count stall cycles until div_done; optional spurious start at spur_at.
  task automatic run_div(input string tag, input logic s, input logic u,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input int exp_stall, input int spur_at);
    int cyc, stalls;
    op_divs = s; op_divu = u; dividend = a; divisor = b;
    tick();
    op_divs = 1'b0; op_divu = 1'b0;
    cyc = 1; stalls = 0;
    while (!div_done && cyc < 200) begin
      if (div_stall) stalls++;
      if (cyc == spur_at) begin
        op_divu = 1'b1; dividend = 32'd200; divisor = 32'd3;
      end
      tick();
      op_divu = 1'b0;
      cyc++;
    end
    check({tag, "_stall"}, stalls, exp_stall);
    check({tag, "_done_cyc"}, cyc, exp_stall + 1);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    tick();
    check({tag, "_done_pulse"}, {31'd0, div_done}, 32'd0);
    check({tag, "_stall_end"}, {31'd0, div_stall}, 32'd0);
  endtask

  initial begin
    int dones;
    rst = 1'b0; op_divs = 1'b0; op_divu = 1'b0; div_abort = 1'b0;
    dividend = '0; divisor = '0;
    tick(); tick();
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_stall", {31'd0, div_stall}, 32'd0);
    check("rst_done", {31'd0, div_done}, 32'd0);
    rst = 1'b1;
    tick();

    run_div("u100_7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 33, 5);
    run_div("s_m7_2", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 0);
    run_div("s_7_m2", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 0);
    run_div("both_m7_2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 0);
    run_div("s_ovf", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 0);
    run_div("u_max_1", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33, 0);
    run_div("s_dz", 1'b1, 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 33, 0);
    run_div("u_dz", 1'b0, 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 33, 0);
    run_div("s_dz_neg", 1'b1, 1'b0, 32'h8765_4321, 32'd0, 32'hFFFF_FFFF, 32'h8765_4321, 33, 0);
    run_div("u_3_10", 1'b0, 1'b1, 32'd3, 32'd10, 32'd0, 32'd3, SMALL_STALL, 0);
    run_div("s_m3_10", 1'b1, 1'b0, 32'hFFFF_FFFD, 32'd10, 32'd0, 32'hFFFF_FFFD, SMALL_STALL, 0);
    run_div("u100_7b", 1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 33, 0);

    // Abort at cycle 10 of 50/5: no completion, prior results held.
    op_divu = 1'b1; dividend = 32'd50; divisor = 32'd5;
    tick();
    op_divu = 1'b0;
    dones = 0;
    for (int c = 1; c < 11; c++) begin
      if (div_done) dones++;
      if (c == 10) div_abort = 1'b1;
      tick();
    end
    div_abort = 1'b0;
    check("abort_stall", {31'd0, div_stall}, 32'd0);
    check("abort_done", {31'd0, div_done}, 32'd0);
    check("abort_q", quotient, 32'd14);
    check("abort_r", remainder, 32'd2);
    tick();
    if (div_done) dones++;
    check("abort_no_done", dones, 0);
    check("abort_idle", {31'd0, div_stall}, 32'd0);
    run_div("u50_5", 1'b0, 1'b1, 32'd50, 32'd5, 32'd10, 32'd0, 33, 0);

    // Abort in IDLE drops a simultaneous start.
    op_divu = 1'b1; div_abort = 1'b1; dividend = 32'd9; divisor = 32'd2;
    tick();
    op_divu = 1'b0; div_abort = 1'b0;
    check("idle_abort_stall", {31'd0, div_stall}, 32'd0);
    tick();
    check("idle_abort_stall2", {31'd0, div_stall}, 32'd0);
    check("idle_abort_q", quotient, 32'd10);

    // Asynchronous reset at cycle 20 of a division.
    op_divu = 1'b1; dividend = 32'd77; divisor = 32'd3;
    tick();
    op_divu = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    #2 rst = 1'b0;
    #1;
    check("arst_q", quotient, 32'd0);
    check("arst_r", remainder, 32'd0);
    check("arst_stall", {31'd0, div_stall}, 32'd0);
    tick();
    check("arst_hold_stall", {31'd0, div_stall}, 32'd0);
    rst = 1'b1;
    tick();
    run_div("post_rst", 1'b0, 1'b1, 32'd77, 32'd3, 32'd25, 32'd2, 33, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
